// File: rtl/daq_cmd_pkg.sv
// Shared constants, state type and helper functions for the DAQ command decoder.
// Imported by the decoder top and its staging buffer.
package daq_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;
  localparam logic [7:0] OP_RESET = 8'h04;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_HEADER = 3'd1;
  localparam logic [2:0] ERR_LENGTH = 3'd2;
  localparam logic [2:0] ERR_TAILER = 3'd3;
  localparam logic [2:0] ERR_CSUM   = 3'd4;
  localparam logic [2:0] ERR_RANGE  = 3'd5;

  localparam logic [7:0] DEF_HEADER = 8'hF0;
  localparam logic [7:0] DEF_TAILER = 8'hAA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TAIL    = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  // Running frame checksum: both halves of every payload word, modulo 2^16.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [31:0] w);
    return acc + w[31:16] + w[15:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/daq_cmd_stage_buf.sv
// Payload staging RAM: filled while a frame streams in, drained one word per
// cycle while a validated WRITE is committed to the register file.
module daq_cmd_stage_buf
  import daq_cmd_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_adv,
  output logic [31:0] rd_data,
  output logic [7:0]  wr_cnt,
  output logic [7:0]  rd_cnt
);

  localparam int         IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] DEPTH = 8'(MAX_LEN);

  logic [31:0] mem_q [MAX_LEN];
  logic [7:0]  wr_cnt_d;
  logic [7:0]  wr_cnt_q;
  logic [7:0]  rd_cnt_d;
  logic [7:0]  rd_cnt_q;
  logic        wr_hit;

  // Index update; a frame start rewinds both indices.
  always_comb begin
    wr_hit = wr_en && (wr_cnt_q < DEPTH);
    if (clr) begin
      wr_cnt_d = 8'd0;
      rd_cnt_d = 8'd0;
    end else begin
      wr_cnt_d = wr_hit ? (wr_cnt_q + 8'd1) : wr_cnt_q;
      rd_cnt_d = rd_adv ? (rd_cnt_q + 8'd1) : rd_cnt_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Storage array; contents are only ever read after being written this frame.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem_q[wr_cnt_q[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_cnt_q[IDX_W-1:0]];
  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;

endmodule

// File: rtl/daq_cmd_decoder.sv
// Host command receiver on the Xillybus write_32 stream: parses and validates
// framed commands, commits register writes and drives the DAQ run/reset controls.
module daq_cmd_decoder
  import daq_cmd_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter int         MAX_LEN  = 8,
  parameter logic [7:0] HEADER   = DEF_HEADER,
  parameter logic [7:0] TAILER   = DEF_TAILER
) (
  input  logic                        bus_clk,
  input  logic                        reset,
  input  logic                        user_w_write_32_wren,
  input  logic [31:0]                 user_w_write_32_data,
  output logic                        user_w_write_32_full,
  input  logic                        user_w_write_32_open,
  input  logic [$clog2(NUM_REGS)-1:0] cfg_rd_addr,
  output logic [31:0]                 cfg_rd_data,
  output logic                        daq_run,
  output logic                        daq_reset_pulse,
  output logic                        busy,
  output logic [15:0]                 frame_ok_cnt,
  output logic [15:0]                 frame_err_cnt,
  output logic [2:0]                  last_err
);

  localparam int         ADDR_W   = $clog2(NUM_REGS);
  localparam logic [8:0] REG_SPAN = 9'(NUM_REGS);
  localparam logic [7:0] LEN_MAX  = 8'(MAX_LEN);

  state_e      state_d;
  state_e      state_q;
  logic [7:0]  op_d;
  logic [7:0]  op_q;
  logic [7:0]  addr_d;
  logic [7:0]  addr_q;
  logic [7:0]  len_d;
  logic [7:0]  len_q;
  logic [15:0] csum_d;
  logic [15:0] csum_q;
  logic [15:0] ok_cnt_d;
  logic [15:0] ok_cnt_q;
  logic [15:0] err_cnt_d;
  logic [15:0] err_cnt_q;
  logic [2:0]  last_err_d;
  logic [2:0]  last_err_q;
  logic        run_d;
  logic        run_q;
  logic        pulse_d;
  logic        pulse_q;
  logic        full_d;
  logic        full_q;
  logic        busy_d;
  logic        busy_q;
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] regs_q [NUM_REGS];

  logic              accept;
  logic [7:0]        w_tag;
  logic [7:0]        w_op;
  logic [7:0]        w_addr;
  logic [7:0]        w_len;
  logic [15:0]       w_csum;
  logic              op_known;
  logic              cmd_bad;
  logic              payload_last;
  logic              commit_last;
  logic [ADDR_W-1:0] commit_addr;

  logic        stg_clr;
  logic        stg_wr;
  logic        stg_adv;
  logic [31:0] stg_rd_data;
  logic [7:0]  stg_wr_cnt;
  logic [7:0]  stg_rd_cnt;

  daq_cmd_stage_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_stage (
    .clk     (bus_clk),
    .reset   (reset),
    .clr     (stg_clr),
    .wr_en   (stg_wr),
    .wr_data (user_w_write_32_data),
    .rd_adv  (stg_adv),
    .rd_data (stg_rd_data),
    .wr_cnt  (stg_wr_cnt),
    .rd_cnt  (stg_rd_cnt)
  );

  assign accept = user_w_write_32_wren && !full_q;
  assign w_tag  = user_w_write_32_data[31:24];
  assign w_op   = user_w_write_32_data[23:16];
  assign w_addr = user_w_write_32_data[15:8];
  assign w_len  = user_w_write_32_data[7:0];
  assign w_csum = user_w_write_32_data[15:0];

  // Command legality is judged on the latched header fields once the tail arrives.
  assign op_known     = (op_q >= OP_WRITE) && (op_q <= OP_RESET);
  assign cmd_bad      = !op_known
                     || ((op_q != OP_WRITE) && (len_q != 8'd0))
                     || (({1'b0, addr_q} + {1'b0, len_q}) > REG_SPAN);
  assign payload_last = ((stg_wr_cnt + 8'd1) == len_q);
  assign commit_last  = (stg_rd_cnt == (len_q - 8'd1));
  assign commit_addr  = ADDR_W'(addr_q + stg_rd_cnt);

  // Frame parser, validation and commit sequencing.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    csum_d     = csum_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    last_err_d = last_err_q;
    run_d      = run_q;
    pulse_d    = 1'b0;
    regs_d     = regs_q;
    stg_clr    = 1'b0;
    stg_wr     = 1'b0;
    stg_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!accept) begin
          state_d = IDLE;
        end else if (w_tag != HEADER) begin
          err_cnt_d  = sat_inc16(err_cnt_q);
          last_err_d = ERR_HEADER;
        end else if (w_len > LEN_MAX) begin
          err_cnt_d  = sat_inc16(err_cnt_q);
          last_err_d = ERR_LENGTH;
        end else begin
          op_d    = w_op;
          addr_d  = w_addr;
          len_d   = w_len;
          csum_d  = 16'h0000;
          stg_clr = 1'b1;
          state_d = (w_len == 8'd0) ? TAIL : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!user_w_write_32_open) begin
          state_d = IDLE;
        end else if (accept) begin
          stg_wr  = 1'b1;
          csum_d  = csum_add(csum_q, user_w_write_32_data);
          state_d = payload_last ? TAIL : PAYLOAD;
        end else begin
          state_d = PAYLOAD;
        end
      end
      TAIL: begin
        if (!user_w_write_32_open) begin
          state_d = IDLE;
        end else if (!accept) begin
          state_d = TAIL;
        end else if (w_tag != TAILER) begin
          state_d    = IDLE;
          err_cnt_d  = sat_inc16(err_cnt_q);
          last_err_d = ERR_TAILER;
        end else if (w_csum != csum_q) begin
          state_d    = IDLE;
          err_cnt_d  = sat_inc16(err_cnt_q);
          last_err_d = ERR_CSUM;
        end else if (cmd_bad) begin
          state_d    = IDLE;
          err_cnt_d  = sat_inc16(err_cnt_q);
          last_err_d = ERR_RANGE;
        end else if ((op_q == OP_WRITE) && (len_q != 8'd0)) begin
          state_d = COMMIT;
        end else begin
          state_d  = IDLE;
          ok_cnt_d = sat_inc16(ok_cnt_q);
          case (op_q)
            OP_START: run_d = 1'b1;
            OP_STOP:  run_d = 1'b0;
            OP_RESET: begin
              run_d   = 1'b0;
              pulse_d = 1'b1;
            end
            default:  run_d = run_q;
          endcase
        end
      end
      COMMIT: begin
        // Drains the staging buffer; the open flag is ignored until done.
        regs_d[commit_addr] = stg_rd_data;
        stg_adv             = 1'b1;
        if (commit_last) begin
          state_d  = IDLE;
          ok_cnt_d = sat_inc16(ok_cnt_q);
        end else begin
          state_d = COMMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    full_d = (state_d == COMMIT);
    busy_d = (state_d != IDLE);
  end

  // State, counters, controls and register file.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 8'h00;
      addr_q     <= 8'h00;
      len_q      <= 8'h00;
      csum_q     <= 16'h0000;
      ok_cnt_q   <= 16'h0000;
      err_cnt_q  <= 16'h0000;
      last_err_q <= ERR_NONE;
      run_q      <= 1'b0;
      pulse_q    <= 1'b0;
      full_q     <= 1'b1;
      busy_q     <= 1'b0;
      regs_q     <= '{default: 32'h0000_0000};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
      last_err_q <= last_err_d;
      run_q      <= run_d;
      pulse_q    <= pulse_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      regs_q     <= regs_d;
    end
  end

  assign user_w_write_32_full = full_q;
  assign cfg_rd_data          = regs_q[cfg_rd_addr];
  assign daq_run              = run_q;
  assign daq_reset_pulse      = pulse_q;
  assign busy                 = busy_q;
  assign frame_ok_cnt         = ok_cnt_q;
  assign frame_err_cnt        = err_cnt_q;
  assign last_err             = last_err_q;

endmodule

// File: tb/tb_daq_cmd_decoder.sv
// Randomised and directed bench for daq_cmd_decoder against a frame-level
// reference model derived from the command protocol rules.
module tb_daq_cmd_decoder;
  import daq_cmd_pkg::*;

  localparam int         NUM_REGS = 16;
  localparam int         MAX_LEN  = 8;
  localparam logic [7:0] HDR      = 8'hF0;
  localparam logic [7:0] TLR      = 8'hAA;

  logic        bus_clk = 1'b0;
  logic        reset = 1'b1;
  logic        wren = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        open = 1'b1;
  logic        full;
  logic [3:0]  cfg_rd_addr = 4'd0;
  logic [31:0] cfg_rd_data;
  logic        daq_run;
  logic        daq_reset_pulse;
  logic        busy;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic [2:0]  last_err;

  always #5 bus_clk = ~bus_clk;

  daq_cmd_decoder #(
    .NUM_REGS (NUM_REGS),
    .MAX_LEN  (MAX_LEN),
    .HEADER   (HDR),
    .TAILER   (TLR)
  ) dut (
    .bus_clk              (bus_clk),
    .reset                (reset),
    .user_w_write_32_wren (wren),
    .user_w_write_32_data (wdata),
    .user_w_write_32_full (full),
    .user_w_write_32_open (open),
    .cfg_rd_addr          (cfg_rd_addr),
    .cfg_rd_data          (cfg_rd_data),
    .daq_run              (daq_run),
    .daq_reset_pulse      (daq_reset_pulse),
    .busy                 (busy),
    .frame_ok_cnt         (ok_cnt),
    .frame_err_cnt        (err_cnt),
    .last_err             (last_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_ok;
  int          m_err;
  int          m_last;
  int          m_run;
  logic [31:0] m_regs [NUM_REGS];
  logic [31:0] pay [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ok = 0; m_err = 0; m_last = 0; m_run = 0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
  endtask

  task automatic model_error(input int code);
    if (m_err < 65535) m_err++;
    m_last = code;
  endtask

  function automatic int frame_csum(input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(pay[i][31:16]) + int'(pay[i][15:0]);
    return s % 65536;
  endfunction

  // Outcome of one complete frame, decided straight from the protocol rules.
  task automatic model_frame(input int op, input int addr, input int len, input logic [31:0] tail);
    if (len > MAX_LEN) model_error(2);
    else if (tail[31:24] != TLR) model_error(3);
    else if (int'(tail[15:0]) != frame_csum(len)) model_error(4);
    else if (op < 1 || op > 4 || (op != 1 && len != 0) || addr + len > NUM_REGS) model_error(5);
    else begin
      if (op == 1) for (int i = 0; i < len; i++) m_regs[addr + i] = pay[i];
      else if (op == 2) m_run = 1;
      else m_run = 0;
      if (m_ok < 65535) m_ok++;
    end
  endtask

  // Presents one word; while full, random junk strobes must be dropped.
  task automatic drive_word(input logic [31:0] w);
    int guard = 0;
    @(negedge bus_clk);
    wren = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge bus_clk);
    while (full !== 1'b0 && guard < 200) begin
      wren  = 1'($urandom_range(0, 1));
      wdata = $urandom();
      @(negedge bus_clk);
      guard++;
    end
    if (guard >= 200) check("full_stuck", 32'(full), 32'd0);
    wren  = 1'b1;
    wdata = w;
    @(posedge bus_clk);
    #1;
    wren = 1'b0;
  endtask

  task automatic send_body(input int op, input int addr, input int len);
    drive_word({HDR, 8'(op), 8'(addr), 8'(len)});
    if (len <= MAX_LEN) for (int i = 0; i < len; i++) drive_word(pay[i]);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy !== 1'b0 || full !== 1'b0) && guard < 300) begin
      @(negedge bus_clk);
      guard++;
    end
    if (guard >= 300) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_ok"}, 32'(ok_cnt), m_ok);
    check({tag, "_err"}, 32'(err_cnt), m_err);
    check({tag, "_last"}, 32'(last_err), m_last);
    check({tag, "_run"}, 32'(daq_run), m_run);
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_rd_addr = 4'(i);
      #1;
      check($sformatf("%s_reg%0d", tag, i), cfg_rd_data, m_regs[i]);
    end
  endtask

  task automatic run_frame(input int op, input int addr, input int len, input logic [31:0] tail);
    send_body(op, addr, len);
    if (len <= MAX_LEN) drive_word(tail);
    model_frame(op, addr, len, tail);
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge bus_clk);
    reset = 1'b1; wren = 1'b0; open = 1'b1;
    repeat (2) @(negedge bus_clk);
    check("rst_full", 32'(full), 32'd1);
    check("rst_run", 32'(daq_run), 32'd0);
    check("rst_pulse", 32'(daq_reset_pulse), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge bus_clk);
    compare_all("rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int nfull;
    do_reset();

    // WRITE addr 2 len 3: one register per cycle, full for exactly len cycles.
    pay[0] = 32'h0001_0002; pay[1] = 32'h0003_0004; pay[2] = 32'h0005_0006;
    send_body(1, 2, 3);
    drive_word({TLR, 8'h00, 16'h0015});
    nfull = 0;
    for (int i = 0; i < 3; i++) begin
      nfull += int'(full);
      cfg_rd_addr = 4'(2 + i);
      #1;
      check("t1_reg_before", cfg_rd_data, 32'h0);
      @(posedge bus_clk);
      #1;
      check("t1_reg_after", cfg_rd_data, pay[i]);
    end
    nfull += int'(full);
    check("t1_full_cycles", 32'(nfull), 32'd3);
    model_frame(1, 2, 3, {TLR, 8'h00, 16'h0015});
    wait_idle();
    compare_all("t1");

    // START then STOP, each acting in the cycle after its tail.
    check("t2_run_pre", 32'(daq_run), 32'd0);
    send_body(2, 0, 0);
    drive_word({TLR, 8'h00, 16'h0000});
    check("t2_run_rise", 32'(daq_run), 32'd1);
    model_frame(2, 0, 0, {TLR, 8'h00, 16'h0000});
    send_body(3, 0, 0);
    drive_word({TLR, 8'h00, 16'h0000});
    check("t2_run_fall", 32'(daq_run), 32'd0);
    model_frame(3, 0, 0, {TLR, 8'h00, 16'h0000});
    wait_idle();
    compare_all("t2");

    // Bad checksum leaves registers alone; the next frame still lands.
    do_reset();
    pay[0] = 32'h0001_0002; pay[1] = 32'h0003_0004; pay[2] = 32'h0005_0006;
    run_frame(1, 5, 3, {TLR, 8'h00, 16'h0016});
    compare_all("t3_bad");
    pay[0] = $urandom(); pay[1] = $urandom();
    run_frame(1, 9, 2, {TLR, 8'h00, 16'(frame_csum(2))});
    compare_all("t3_good");

    // Hunt mode discards stray words before a real header.
    do_reset();
    drive_word(32'h1234_5678); model_error(1);
    drive_word(32'hDEAD_BEEF); model_error(1);
    compare_all("t4_stray");
    run_frame(2, 0, 0, {TLR, 8'h00, 16'h0000});
    compare_all("t4_start");

    // Over-long frame, then a write running past the last register.
    do_reset();
    run_frame(1, 0, 9, 32'h0);
    compare_all("t5_len");
    pay[0] = $urandom(); pay[1] = $urandom();
    run_frame(1, 15, 2, {TLR, 8'h00, 16'(frame_csum(2))});
    compare_all("t5_range");

    // Host closes the file mid-payload.
    do_reset();
    pay[0] = $urandom(); pay[1] = $urandom(); pay[2] = $urandom(); pay[3] = $urandom();
    drive_word({HDR, OP_WRITE, 8'd0, 8'd4});
    drive_word(pay[0]);
    drive_word(pay[1]);
    @(negedge bus_clk); open = 1'b0;
    @(negedge bus_clk); open = 1'b1;
    check("t6_busy", 32'(busy), 32'd0);
    compare_all("t6_drop");
    run_frame(1, 0, 4, {TLR, 8'h00, 16'(frame_csum(4))});
    compare_all("t6_after");

    // RESET opcode while running.
    run_frame(2, 0, 0, {TLR, 8'h00, 16'h0000});
    send_body(4, 0, 0);
    drive_word({TLR, 8'h00, 16'h0000});
    check("t7_pulse_hi", 32'(daq_reset_pulse), 32'd1);
    check("t7_run_lo", 32'(daq_run), 32'd0);
    @(posedge bus_clk);
    #1;
    check("t7_pulse_lo", 32'(daq_reset_pulse), 32'd0);
    model_frame(4, 0, 0, {TLR, 8'h00, 16'h0000});
    compare_all("t7");

    // Reset while a commit is part-way through.
    for (int i = 0; i < MAX_LEN; i++) pay[i] = $urandom() | 32'h1;
    send_body(1, 0, MAX_LEN);
    drive_word({TLR, 8'h00, 16'(frame_csum(MAX_LEN))});
    repeat (3) @(posedge bus_clk);
    do_reset();

    for (int n = 0; n < 200; n++) begin
      int kind;
      int op;
      int addr;
      int len;
      int k;
      logic [15:0] cs;
      logic [31:0] tail;
      logic [31:0] w;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(0, MAX_LEN);
      for (int i = 0; i < 256; i++) pay[i] = $urandom();
      op   = 1;
      addr = $urandom_range(0, NUM_REGS - len);
      case (kind)
        2: begin op = $urandom_range(2, 4); len = 0; addr = $urandom_range(0, 31); end
        3: op = $urandom_range(0, 255);
        6: addr = $urandom_range(0, 20);
        7: len = $urandom_range(MAX_LEN + 1, 255);
        default: ;
      endcase
      cs   = 16'(frame_csum((len <= MAX_LEN) ? len : 0));
      tail = {TLR, 8'h00, cs};
      if (kind == 4) tail[15:0] = cs ^ 16'($urandom_range(1, 65535));
      if (kind == 5) begin
        tail[31:24] = 8'($urandom_range(0, 255));
        if (tail[31:24] == TLR) tail[31:24] = 8'h55;
        if ($urandom_range(0, 1) == 1) tail[15:0] = cs ^ 16'h0001;
      end
      if (kind == 8) begin
        w = $urandom();
        if (w[31:24] == HDR) w[31:24] = 8'h0F;
        drive_word(w);
        model_error(1);
      end else if (kind == 9) begin
        k = $urandom_range(0, len);
        drive_word({HDR, OP_WRITE, 8'(addr), 8'(len)});
        for (int i = 0; i < k; i++) drive_word(pay[i]);
        @(negedge bus_clk); open = 1'b0;
        @(negedge bus_clk); open = 1'b1;
      end else begin
        run_frame(op, addr, len, tail);
      end
      wait_idle();
      compare_all($sformatf("rnd%0d_k%0d", n, kind));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
